// File: rtl/cmp_arbiter.sv
// cmp_arbiter: round-robin arbiter that shares one unsigned magnitude comparator
// among NUM_REQ requesters. It grants one operand pair, lets the comparator settle
// for a cycle, registers the flags and returns them with the requester index.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/req_ready   per-requester request handshake (req_ready is one-hot or zero)
//   req_a/req_b           packed operands, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   rsp_valid/rsp_ready   response handshake
//   rsp_id                index of the requester being answered
//   rsp_equal/lower/greater  registered comparison flags (exactly one set per response)
//   cmp_count             completed responses, wraps at 16 bits
module cmp_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ID_W       = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [ID_W-1:0]               rsp_id,
    output logic                          rsp_equal,
    output logic                          rsp_lower,
    output logic                          rsp_greater,
    output logic [15:0]                   cmp_count
);

    localparam int unsigned CNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EVAL = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [ID_W-1:0]         ptr_q, ptr_d;
    logic [DATA_WIDTH-1:0]   op_a_q, op_a_d;
    logic [DATA_WIDTH-1:0]   op_b_q, op_b_d;
    logic [ID_W-1:0]         rsp_id_q, rsp_id_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic                    rsp_equal_q, rsp_equal_d;
    logic                    rsp_lower_q, rsp_lower_d;
    logic                    rsp_greater_q, rsp_greater_d;
    logic [CNT_W-1:0]        cmp_count_q, cmp_count_d;

    logic [DATA_WIDTH-1:0]   a_arr_c [NUM_REQ];
    logic [DATA_WIDTH-1:0]   b_arr_c [NUM_REQ];
    logic                    grant_found_c;
    logic [ID_W-1:0]         grant_id_c;
    logic [ID_W-1:0]         ptr_next_c;
    logic                    cmp_equal_c, cmp_lower_c, cmp_greater_c;

    // Unpack the flat operand buses per requester.
    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            a_arr_c[i] = req_a[i*DATA_WIDTH +: DATA_WIDTH];
            b_arr_c[i] = req_b[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Round-robin search: first valid requester at or after ptr, wrapping.
    always_comb begin
        int unsigned idx;
        idx           = 0;
        grant_found_c = 1'b0;
        grant_id_c    = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = 32'(ptr_q) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!grant_found_c && req_valid[ID_W'(idx)]) begin
                grant_found_c = 1'b1;
                grant_id_c    = ID_W'(idx);
            end
        end
        ptr_next_c = (grant_id_c == ID_W'(NUM_REQ - 1)) ? '0 : grant_id_c + ID_W'(1);
    end

    // Shared comparator, fed only from the captured operand registers.
    always_comb begin
        cmp_equal_c   = (op_a_q == op_b_q);
        cmp_lower_c   = (op_a_q <  op_b_q);
        cmp_greater_c = (op_a_q >  op_b_q);
    end

    // Grant is combinational from state and req_valid; held low while in reset.
    always_comb begin
        req_ready = '0;
        if (rst_n && (state_q == ST_IDLE) && grant_found_c) begin
            req_ready[grant_id_c] = 1'b1;
        end
    end

    // Next-state and register updates.
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        op_a_d        = op_a_q;
        op_b_d        = op_b_q;
        rsp_id_d      = rsp_id_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_equal_d   = rsp_equal_q;
        rsp_lower_d   = rsp_lower_q;
        rsp_greater_d = rsp_greater_q;
        cmp_count_d   = cmp_count_q;

        case (state_q)
            ST_IDLE: begin
                if (grant_found_c) begin
                    op_a_d   = a_arr_c[grant_id_c];
                    op_b_d   = b_arr_c[grant_id_c];
                    rsp_id_d = grant_id_c;
                    ptr_d    = ptr_next_c;
                    state_d  = ST_EVAL;
                end
            end
            ST_EVAL: begin
                rsp_equal_d   = cmp_equal_c;
                rsp_lower_d   = cmp_lower_c;
                rsp_greater_d = cmp_greater_c;
                rsp_valid_d   = 1'b1;
                state_d       = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    cmp_count_d = cmp_count_q + CNT_W'(1);
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            ptr_q         <= '0;
            op_a_q        <= '0;
            op_b_q        <= '0;
            rsp_id_q      <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_equal_q   <= 1'b0;
            rsp_lower_q   <= 1'b0;
            rsp_greater_q <= 1'b0;
            cmp_count_q   <= '0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            op_a_q        <= op_a_d;
            op_b_q        <= op_b_d;
            rsp_id_q      <= rsp_id_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_equal_q   <= rsp_equal_d;
            rsp_lower_q   <= rsp_lower_d;
            rsp_greater_q <= rsp_greater_d;
            cmp_count_q   <= cmp_count_d;
        end
    end

    assign rsp_valid   = rsp_valid_q;
    assign rsp_id      = rsp_id_q;
    assign rsp_equal   = rsp_equal_q;
    assign rsp_lower   = rsp_lower_q;
    assign rsp_greater = rsp_greater_q;
    assign cmp_count   = cmp_count_q;

endmodule

// File: tb/tb_cmp_arbiter.sv
// Self-checking bench for cmp_arbiter: expected responses are queued at grant
// time and popped when the DUT presents rsp_valid.
module tb_cmp_arbiter;

    localparam int unsigned NR = 4;
    localparam int unsigned DW = 8;

    logic              clk;
    logic              rst_n;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR*DW-1:0]  req_a;
    logic [NR*DW-1:0]  req_b;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [1:0]        rsp_id;
    logic              rsp_equal;
    logic              rsp_lower;
    logic              rsp_greater;
    logic [15:0]       cmp_count;

    typedef struct packed {
        logic [1:0] id;
        logic [2:0] flags;   // {equal, lower, greater}
    } exp_t;

    exp_t        sb[$];
    int          n_cmp;
    int          n_err;
    logic [15:0] exp_count;

    cmp_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id),
        .rsp_equal(rsp_equal), .rsp_lower(rsp_lower), .rsp_greater(rsp_greater),
        .cmp_count(cmp_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2:0] ref_flags(input logic [7:0] a, input logic [7:0] b);
        if (a == b)     return 3'b100;
        else if (a < b) return 3'b010;
        else            return 3'b001;
    endfunction

    task automatic set_ops(input int i, input logic [7:0] a, input logic [7:0] b);
        req_a[i*DW +: DW] = a;
        req_b[i*DW +: DW] = b;
    endtask

    // Waits (bounded) for rsp_valid, sampling #1 after each falling edge.
    task automatic get_rsp(output bit got);
        got = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk); #1;
            if (rsp_valid === 1'b1) begin
                got = 1'b1;
                return;
            end
        end
    endtask

    task automatic test_reset;
        logic [25:0] obs;
        rst_n = 1'b0;
        @(negedge clk); #1;
        obs = {req_ready, rsp_valid, rsp_id, rsp_equal, rsp_lower, rsp_greater, cmp_count};
        n_cmp++;
        if (obs !== 26'd0) begin
            n_err++; $display("FAIL reset_outputs: got %h expected 0", obs);
        end
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            obs = {req_ready, rsp_valid, rsp_id, rsp_equal, rsp_lower, rsp_greater, cmp_count};
            n_cmp++;
            if (obs !== 26'd0) begin
                n_err++; $display("FAIL idle_after_reset[%0d]: got %h expected 0", c, obs);
            end
        end
    endtask

    task automatic test_single;
        exp_t e;
        exp_t o;
        @(negedge clk);
        set_ops(0, 8'h35, 8'h35);
        req_valid = 4'b0001;
        #1;
        n_cmp++;
        if (req_ready !== 4'b0001) begin
            n_err++; $display("FAIL single_grant: got %b expected 0001", req_ready);
        end
        sb.push_back('{id: 2'd0, flags: ref_flags(8'h35, 8'h35)});
        @(negedge clk);
        req_valid = '0;
        #1;
        n_cmp++;
        if (rsp_valid !== 1'b0 || req_ready !== 4'b0000) begin
            n_err++; $display("FAIL single_eval: got valid=%b ready=%b expected 0/0000", rsp_valid, req_ready);
        end
        @(negedge clk); #1;
        n_cmp++;
        if (rsp_valid !== 1'b1) begin
            n_err++; $display("FAIL single_latency: got rsp_valid=%b expected 1", rsp_valid);
        end
        e = sb.pop_front();
        o = {rsp_id, rsp_equal, rsp_lower, rsp_greater};
        n_cmp++;
        if (o !== e) begin
            n_err++; $display("FAIL single_rsp: got %h expected %h", o, e);
        end
        exp_count = exp_count + 16'd1;
        @(negedge clk); #1;
        n_cmp++;
        if (cmp_count !== exp_count || rsp_valid !== 1'b0) begin
            n_err++; $display("FAIL single_count: got cnt=%0d valid=%b expected %0d/0", cmp_count, rsp_valid, exp_count);
        end
    endtask

    task automatic test_unsigned;
        logic [7:0] ta [3] = '{8'h80, 8'h00, 8'hFF};
        logic [7:0] tb [3] = '{8'h7F, 8'hFF, 8'hFE};
        bit   got;
        exp_t e;
        exp_t o;
        logic [3:0] oh;
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            set_ops(t + 1, ta[t], tb[t]);
            oh = 4'(1 << (t + 1));
            req_valid = oh;
            #1;
            n_cmp++;
            if (req_ready !== oh) begin
                n_err++; $display("FAIL unsigned_grant[%0d]: got %b expected %b", t, req_ready, oh);
            end
            sb.push_back('{id: 2'(t + 1), flags: ref_flags(ta[t], tb[t])});
            @(negedge clk);
            req_valid = '0;
            get_rsp(got);
            n_cmp++;
            if (!got) begin
                n_err++; $display("FAIL unsigned_timeout[%0d]: got no response expected rsp_valid", t);
                void'(sb.pop_front());
            end else begin
                e = sb.pop_front();
                o = {rsp_id, rsp_equal, rsp_lower, rsp_greater};
                if (o !== e) begin
                    n_err++; $display("FAIL unsigned_rsp[%0d]: got %h expected %h", t, o, e);
                end
                n_cmp++;
                if ($countones({rsp_equal, rsp_lower, rsp_greater}) != 1) begin
                    n_err++; $display("FAIL unsigned_onehot[%0d]: got %b expected one flag", t,
                                      {rsp_equal, rsp_lower, rsp_greater});
                end
                exp_count = exp_count + 16'd1;
            end
        end
        @(negedge clk); #1;
        n_cmp++;
        if (cmp_count !== exp_count) begin
            n_err++; $display("FAIL unsigned_count: got %0d expected %0d", cmp_count, exp_count);
        end
    endtask

    task automatic test_fairness;
        int         order [6] = '{0, 1, 2, 3, 0, 1};
        logic [7:0] fa [4] = '{8'h40, 8'h22, 8'h90, 8'hF0};
        logic [7:0] fb [4] = '{8'h40, 8'h33, 8'h10, 8'hF1};
        int   grants;
        int   rsps;
        int   last_grant;
        int   cyc;
        exp_t e;
        exp_t o;
        grants = 0; rsps = 0; last_grant = 0; cyc = 0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_count = '0;
        for (int i = 0; i < 4; i++) set_ops(i, fa[i], fb[i]);
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        while (rsps < 6 && cyc < 40) begin
            #1;
            if (req_ready !== 4'b0000 && grants < 6) begin
                n_cmp++;
                if (req_ready !== 4'(1 << order[grants])) begin
                    n_err++; $display("FAIL fair_grant[%0d]: got %b expected %b", grants, req_ready,
                                      4'(1 << order[grants]));
                end
                if (grants > 0) begin
                    n_cmp++;
                    if (cyc - last_grant != 3) begin
                        n_err++; $display("FAIL fair_spacing[%0d]: got %0d expected 3", grants, cyc - last_grant);
                    end
                end
                sb.push_back('{id: 2'(order[grants]),
                               flags: ref_flags(fa[order[grants]], fb[order[grants]])});
                last_grant = cyc;
                grants++;
            end
            if (rsp_valid === 1'b1) begin
                e = sb.pop_front();
                o = {rsp_id, rsp_equal, rsp_lower, rsp_greater};
                n_cmp++;
                if (o !== e) begin
                    n_err++; $display("FAIL fair_rsp[%0d]: got %h expected %h", rsps, o, e);
                end
                rsps++;
                exp_count = exp_count + 16'd1;
                if (rsps == 6) req_valid = '0;
            end
            @(negedge clk);
            cyc++;
        end
        n_cmp++;
        if (rsps != 6) begin
            n_err++; $display("FAIL fair_timeout: got %0d responses expected 6", rsps);
            sb.delete();
            req_valid = '0;
        end
        #1;
        n_cmp++;
        if (cmp_count !== exp_count) begin
            n_err++; $display("FAIL fair_count: got %0d expected %0d", cmp_count, exp_count);
        end
    endtask

    task automatic test_backpressure;
        bit   got;
        exp_t e;
        exp_t o;
        @(negedge clk);
        rsp_ready = 1'b0;
        set_ops(3, 8'h10, 8'h20);
        req_valid = 4'b1000;
        #1;
        n_cmp++;
        if (req_ready !== 4'b1000) begin
            n_err++; $display("FAIL bp_grant: got %b expected 1000", req_ready);
        end
        sb.push_back('{id: 2'd3, flags: ref_flags(8'h10, 8'h20)});
        @(negedge clk);
        set_ops(0, 8'h55, 8'h44);
        req_valid = 4'b0001;
        get_rsp(got);
        n_cmp++;
        if (!got) begin
            n_err++; $display("FAIL bp_timeout: got no response expected rsp_valid");
        end
        e = sb.pop_front();
        for (int k = 0; k < 5; k++) begin
            o = {rsp_id, rsp_equal, rsp_lower, rsp_greater};
            n_cmp++;
            if (rsp_valid !== 1'b1 || o !== e || req_ready !== 4'b0000 || cmp_count !== exp_count) begin
                n_err++; $display("FAIL bp_hold[%0d]: got v=%b rsp=%h rdy=%b cnt=%0d expected 1/%h/0000/%0d",
                                  k, rsp_valid, o, req_ready, cmp_count, e, exp_count);
            end
            @(negedge clk); #1;
        end
        rsp_ready = 1'b1;
        exp_count = exp_count + 16'd1;
        @(negedge clk); #1;
        n_cmp++;
        if (rsp_valid !== 1'b0 || cmp_count !== exp_count) begin
            n_err++; $display("FAIL bp_release: got v=%b cnt=%0d expected 0/%0d", rsp_valid, cmp_count, exp_count);
        end
        n_cmp++;
        if (req_ready !== 4'b0001) begin
            n_err++; $display("FAIL bp_next_grant: got %b expected 0001", req_ready);
        end
        sb.push_back('{id: 2'd0, flags: ref_flags(8'h55, 8'h44)});
        @(negedge clk);
        req_valid = '0;
        get_rsp(got);
        n_cmp++;
        if (!got) begin
            n_err++; $display("FAIL bp_next_timeout: got no response expected rsp_valid");
            void'(sb.pop_front());
        end else begin
            e = sb.pop_front();
            o = {rsp_id, rsp_equal, rsp_lower, rsp_greater};
            if (o !== e) begin
                n_err++; $display("FAIL bp_next_rsp: got %h expected %h", o, e);
            end
            exp_count = exp_count + 16'd1;
        end
    endtask

    task automatic test_reset_mid;
        bit          got;
        exp_t        e;
        exp_t        o;
        logic [25:0] obs;
        @(negedge clk);
        set_ops(2, 8'hA0, 8'h0A);
        req_valid = 4'b0100;
        #1;
        n_cmp++;
        if (req_ready !== 4'b0100) begin
            n_err++; $display("FAIL rm_grant: got %b expected 0100", req_ready);
        end
        @(negedge clk);
        req_valid = '0;
        #1;
        rst_n = 1'b0;
        #1;
        obs = {req_ready, rsp_valid, rsp_id, rsp_equal, rsp_lower, rsp_greater, cmp_count};
        n_cmp++;
        if (obs !== 26'd0) begin
            n_err++; $display("FAIL rm_reset_outputs: got %h expected 0", obs);
        end
        set_ops(1, 8'h01, 8'h02);
        req_valid = 4'b0110;
        #1;
        n_cmp++;
        if (req_ready !== 4'b0000) begin
            n_err++; $display("FAIL rm_ready_in_reset: got %b expected 0000", req_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp_count = '0;
        #1;
        n_cmp++;
        if (req_ready !== 4'b0010 || rsp_valid !== 1'b0) begin
            n_err++; $display("FAIL rm_first_grant: got rdy=%b v=%b expected 0010/0", req_ready, rsp_valid);
        end
        sb.push_back('{id: 2'd1, flags: ref_flags(8'h01, 8'h02)});
        @(negedge clk);
        req_valid = 4'b0100;
        #1;
        n_cmp++;
        if (rsp_valid !== 1'b0) begin
            n_err++; $display("FAIL rm_no_stale_rsp: got %b expected 0", rsp_valid);
        end
        get_rsp(got);
        n_cmp++;
        if (!got) begin
            n_err++; $display("FAIL rm_timeout1: got no response expected rsp_valid");
            void'(sb.pop_front());
        end else begin
            e = sb.pop_front();
            o = {rsp_id, rsp_equal, rsp_lower, rsp_greater};
            if (o !== e) begin
                n_err++; $display("FAIL rm_rsp1: got %h expected %h", o, e);
            end
            exp_count = exp_count + 16'd1;
        end
        @(negedge clk); #1;
        n_cmp++;
        if (req_ready !== 4'b0100) begin
            n_err++; $display("FAIL rm_grant2: got %b expected 0100", req_ready);
        end
        sb.push_back('{id: 2'd2, flags: ref_flags(8'hA0, 8'h0A)});
        @(negedge clk);
        req_valid = '0;
        get_rsp(got);
        n_cmp++;
        if (!got) begin
            n_err++; $display("FAIL rm_timeout2: got no response expected rsp_valid");
            void'(sb.pop_front());
        end else begin
            e = sb.pop_front();
            o = {rsp_id, rsp_equal, rsp_lower, rsp_greater};
            if (o !== e) begin
                n_err++; $display("FAIL rm_rsp2: got %h expected %h", o, e);
            end
            exp_count = exp_count + 16'd1;
        end
        @(negedge clk); #1;
        n_cmp++;
        if (cmp_count !== exp_count) begin
            n_err++; $display("FAIL rm_count: got %0d expected %0d", cmp_count, exp_count);
        end
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        exp_count = '0;
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        test_reset;
        test_single;
        test_unsigned;
        test_fairness;
        test_backpressure;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before 200000");
        $fatal(1);
    end

endmodule
